// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one pmem line port between the I$ and D$ ports.
// Whole-line grants are held to pmem_resp, then one recovery cycle.
module pmem_arbiter #(
   parameter int unsigned s_line     = 256,
   parameter int unsigned s_addr     = 32,
   parameter bit          fixed_prio = 1'b0,
   parameter int unsigned timeout    = 1024
) (
   input  logic              clk,
   input  logic              reset_n,

   input  logic              i_pmem_read,
   input  logic              i_pmem_write,
   input  logic [s_addr-1:0] i_pmem_addr,
   input  logic [s_line-1:0] i_pmem_wdata,
   output logic [s_line-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,

   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [s_addr-1:0] d_pmem_addr,
   input  logic [s_line-1:0] d_pmem_wdata,
   output logic [s_line-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,

   output logic              pmem_read,
   output logic              pmem_write,
   output logic [s_addr-1:0] pmem_addr,
   output logic [s_line-1:0] pmem_wdata,
   input  logic [s_line-1:0] pmem_rdata,
   input  logic              pmem_resp,

   output logic              busy,
   output logic              timeout_err
);

   localparam int unsigned CW = (timeout > 0) ?
                                $clog2(timeout + 1) : 1;
   localparam bit WDOG_ON = (timeout != 0);
   localparam logic [CW-1:0] TMAX = CW'(timeout);
   localparam logic [CW-1:0] TLAST =
      CW'((timeout == 0) ? 0 : timeout - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D,
      RECOVER
   } state_t;

   state_t          state_q, state_d;
   logic            last_d_q, last_d_d;
   logic [CW-1:0]   cnt_q;
   logic            err_q;
   logic            i_req, d_req;
   logic            tie, only_i, only_d;
   logic            grant_i, grant_d;
   logic            stall;

   assign i_req  = i_pmem_read | i_pmem_write;
   assign d_req  = d_pmem_read | d_pmem_write;
   assign tie    = i_req & d_req;
   assign only_i = i_req & ~d_req;
   assign only_d = d_req & ~i_req;

   assign grant_i = (state_q == GRANT_I);
   assign grant_d = (state_q == GRANT_D);
   assign busy    = grant_i | grant_d;
   assign stall   = busy & ~pmem_resp;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      unique case (state_q)
         IDLE: begin
            unique case (1'b1)
               tie:     state_d = (fixed_prio || !last_d_q) ?
                                  GRANT_D : GRANT_I;
               only_i:  state_d = GRANT_I;
               only_d:  state_d = GRANT_D;
               default: state_d = IDLE;
            endcase
         end
         GRANT_I: begin
            if (pmem_resp) begin
               state_d  = RECOVER;
               last_d_d = 1'b0;
            end
         end
         GRANT_D: begin
            if (pmem_resp) begin
               state_d  = RECOVER;
               last_d_d = 1'b1;
            end
         end
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_addr    = '0;
      pmem_wdata   = '0;
      i_pmem_resp  = 1'b0;
      d_pmem_resp  = 1'b0;
      i_pmem_rdata = '0;
      d_pmem_rdata = '0;
      if (grant_i) begin
         pmem_read   = i_pmem_read;
         pmem_write  = i_pmem_write;
         pmem_addr   = i_pmem_addr;
         pmem_wdata  = i_pmem_wdata;
         i_pmem_resp = pmem_resp;
      end
      if (grant_d) begin
         pmem_read   = d_pmem_read;
         pmem_write  = d_pmem_write;
         pmem_addr   = d_pmem_addr;
         pmem_wdata  = d_pmem_wdata;
         d_pmem_resp = pmem_resp;
      end
      if (busy) begin
         i_pmem_rdata = pmem_rdata;
         d_pmem_rdata = pmem_rdata;
      end
   end

   // grants are only entered from IDLE, so clearing there is entry-clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == IDLE)
            cnt_q <= '0;
         else if (stall && cnt_q != TMAX)
            cnt_q <= cnt_q + CW'(1);
         if (WDOG_ON && stall && cnt_q == TLAST)
            err_q <= 1'b1;
      end
   end

   assign timeout_err = err_q;

endmodule
